eq_coef_load_seq: RTL and testbench

- Sequences software-initiated loads into a double-buffered equaliser coefficient RAM, one instance per EQ path.
- Input is the 32-bit control word from the PPC-to-fabric control register, plus a data word from a companion register.
- Writes always go to the inactive bank. A commit command swaps banks on the next frame sync, so the datapath never sees a half-loaded set.
- Status word is returned to software through a fabric-to-PPC register.

---
 rtl/eq_coef_load_seq_if.sv | 24 ++
 rtl/eq_coef_load_seq.sv | 171 +++++++++++++++++
 tb/tb_eq_coef_load_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/eq_coef_load_seq_if.sv
// Bus bundle between the PPC control/status registers and one EQ coefficient load sequencer.
interface eq_coef_load_seq_if #(
  parameter int ADDR_W = 10,
  parameter int COEF_W = 16
);
  logic [31:0]       ctl_word;
  logic [31:0]       coef_in;
  logic              frame_sync;
  logic              coef_we;
  logic [ADDR_W:0]   coef_addr;
  logic [COEF_W-1:0] coef_dout;
  logic              coef_bank;
  logic [31:0]       status;

  modport master (
    output ctl_word, coef_in, frame_sync,
    input  coef_we, coef_addr, coef_dout, coef_bank, status
  );

  modport slave (
    input  ctl_word, coef_in, frame_sync,
    output coef_we, coef_addr, coef_dout, coef_bank, status
  );
endinterface

// File: rtl/eq_coef_load_seq.sv
// Loads a double-buffered EQ coefficient RAM: writes target the inactive bank,
// and a commit swaps banks on the next frame sync.
//   state     | meaning
//   IDLE      | waiting for a go toggle
//   WRITE     | streaming writes to the inactive bank, one per cycle
//   SWAP_WAIT | commit accepted, bank swap on next frame_sync
module eq_coef_load_seq #(
  parameter int ADDR_W = 10,
  parameter int COEF_W = 16
) (
  input  logic               OPB_Clk,
  input  logic               OPB_Rst,
  eq_coef_load_seq_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] CMD_ONE    = 2'd0;
  localparam logic [1:0] CMD_FILL   = 2'd1;
  localparam logic [1:0] CMD_COMMIT = 2'd2;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   R_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FULL  = R_ONE << ADDR_W;

  state_t state, state_nxt;

  logic              go_last;
  logic              go_evt;
  logic [1:0]        cmd_f;
  logic              clr_f;
  logic [ADDR_W-1:0] addr_f;
  logic [ADDR_W-1:0] cnt_f;
  logic [ADDR_W:0]   sum_f;
  logic [ADDR_W:0]   room_f;
  logic [ADDR_W:0]   fill_len;
  logic              range_hit;

  logic              accept;
  logic              overrun;
  logic              wr_fire;
  logic              swap_fire;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remain;
  logic [COEF_W-1:0] data_r;
  logic              wbank;
  logic              bank_r;
  logic              err_range;
  logic              err_ovr;
  logic [15:0]       cmd_cnt;
  logic              we_r;
  logic [ADDR_W:0]   addr_r;
  logic [COEF_W-1:0] dout_r;
  logic              unused_ctl;

  assign go_evt  = bus.ctl_word[31] ^ go_last;
  assign cmd_f   = bus.ctl_word[30:29];
  assign clr_f   = bus.ctl_word[28];
  assign addr_f  = bus.ctl_word[ADDR_W+15:16];
  assign cnt_f   = bus.ctl_word[ADDR_W-1:0];

  // FILL is clipped at the top of the bank rather than wrapping to 0
  assign sum_f     = {1'b0, addr_f} + {1'b0, cnt_f};
  assign room_f    = FULL - {1'b0, addr_f};
  assign range_hit = (cmd_f == CMD_FILL) && sum_f[ADDR_W];
  assign fill_len  = sum_f[ADDR_W] ? room_f : ({1'b0, cnt_f} + R_ONE);

  assign unused_ctl = ^{bus.ctl_word, bus.coef_in};

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (go_evt) state_nxt = (cmd_f == CMD_COMMIT) ? SWAP_WAIT : WRITE;
      end
      WRITE: begin
        if (remain == '0) state_nxt = IDLE;
      end
      SWAP_WAIT: begin
        if (bus.frame_sync) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    overrun   = 1'b0;
    wr_fire   = 1'b0;
    swap_fire = 1'b0;
    if (go_evt) begin
      if (state == IDLE) accept  = 1'b1;
      else               overrun = 1'b1;
    end
    if (state == WRITE && remain != '0)     wr_fire   = 1'b1;
    if (state == SWAP_WAIT && bus.frame_sync) swap_fire = 1'b1;
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      go_last   <= 1'b0;
      cur_addr  <= '0;
      remain    <= '0;
      data_r    <= '0;
      wbank     <= 1'b0;
      bank_r    <= 1'b0;
      err_range <= 1'b0;
      err_ovr   <= 1'b0;
      cmd_cnt   <= '0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      dout_r    <= '0;
    end else begin
      go_last <= bus.ctl_word[31];
      we_r    <= wr_fire;
      if (wr_fire) begin
        addr_r   <= {wbank, cur_addr};
        dout_r   <= data_r;
        cur_addr <= cur_addr + A_ONE;
        remain   <= remain - R_ONE;
      end
      if (accept) begin
        cmd_cnt <= cmd_cnt + 16'd1;
        wbank   <= ~bank_r;
        case (cmd_f)
          CMD_ONE: begin
            cur_addr <= addr_f;
            remain   <= R_ONE;
            data_r   <= bus.coef_in[COEF_W-1:0];
          end
          CMD_FILL: begin
            cur_addr <= addr_f;
            remain   <= fill_len;
            data_r   <= bus.coef_in[COEF_W-1:0];
          end
          CMD_COMMIT: begin
            remain <= '0;
          end
          default: begin
            cur_addr <= '0;
            remain   <= FULL;
            data_r   <= '0;
          end
        endcase
        if (clr_f) begin
          err_range <= 1'b0;
          err_ovr   <= 1'b0;
        end
        if (range_hit) err_range <= 1'b1;
      end
      if (overrun)   err_ovr <= 1'b1;
      if (swap_fire) bank_r  <= ~bank_r;
    end
  end

  assign bus.coef_we   = we_r;
  assign bus.coef_addr = addr_r;
  assign bus.coef_dout = dout_r;
  assign bus.coef_bank = bank_r;
  assign bus.status    = {state != IDLE, state == SWAP_WAIT, bank_r, err_range,
                          err_ovr, 11'd0, cmd_cnt};
endmodule

// File: tb/tb_eq_coef_load_seq.sv
// Scoreboard bench for eq_coef_load_seq: expected RAM writes are queued when a
// command is issued and popped as coef_we strobes appear.
module tb_eq_coef_load_seq;
  localparam int AW = 10;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eq_coef_load_seq_if #(.ADDR_W(AW), .COEF_W(CW)) bus ();

  eq_coef_load_seq #(.ADDR_W(AW), .COEF_W(CW)) dut (
    .OPB_Clk (clk),
    .OPB_Rst (rst),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [AW:0]   a;
    logic [CW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad = 0;
  int  we_cnt = 0;
  bit  go_bit = 1'b0;
  bit  exp_bank = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.coef_we) begin
      we_cnt++;
      if (exp_q.size() == 0) chk("extra_we", 64'(bus.coef_we), 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.coef_addr), 64'(mon_e.a));
        chk("wr_data", 64'(bus.coef_dout), 64'(mon_e.d));
      end
    end
  end

  task automatic issue(input logic [1:0] cmd, input bit clr, input int addr,
                       input int cnt, input int data);
    logic [31:0] w;
    go_bit = ~go_bit;
    w = '0;
    w[31] = go_bit;
    w[30:29] = cmd;
    w[28] = clr;
    w[AW+15:16] = addr[AW-1:0];
    w[AW-1:0] = cnt[AW-1:0];
    bus.ctl_word = w;
    bus.coef_in = data;
    @(posedge clk);
    #1;
  endtask

  task automatic toggle_go();
    go_bit = ~go_bit;
    bus.ctl_word[31] = go_bit;
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input bit bank, input int start, input int n, input int data);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.a = {bank, AW'(start + i)};
      e.d = data[CW-1:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.status[31] && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_idle"}, 64'(bus.status[31]), 64'd0);
    chk({tag, "_qempty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ctl_word = '0;
    bus.frame_sync = 1'b0;
    go_bit = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_bank = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    bus.ctl_word = '0;
    bus.coef_in = '0;
    bus.frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_we", 64'(bus.coef_we), 64'd0);
    chk("rst_addr", 64'(bus.coef_addr), 64'd0);
    chk("rst_dout", 64'(bus.coef_dout), 64'd0);
    chk("rst_bank", 64'(bus.coef_bank), 64'd0);
    chk("rst_status", 64'(bus.status), 64'd0);

    // single write: strobe exactly one cycle after the capture edge
    issue(2'd0, 1'b0, 5, 0, 'h1234);
    push_wr(~exp_bank, 5, 1, 'h1234);
    chk("t1_busy", 64'(bus.status[31]), 64'd1);
    chk("t1_we_k", 64'(bus.coef_we), 64'd0);
    @(posedge clk); #1;
    chk("t1_we_k1", 64'(bus.coef_we), 64'd1);
    @(posedge clk); #1;
    chk("t1_we_k2", 64'(bus.coef_we), 64'd0);
    chk("t1_status", 64'(bus.status), 64'h1);
    chk("t1_hold_addr", 64'(bus.coef_addr), 64'({1'b1, 10'd5}));
    chk("t1_hold_dout", 64'(bus.coef_dout), 64'h1234);
    chk("t1_qempty", 64'(exp_q.size()), 64'd0);

    // fill clipped at the top of the bank
    issue(2'd1, 1'b0, 1020, 9, 'hBEEF);
    push_wr(~exp_bank, 1020, 4, 'hBEEF);
    wait_idle("t2", 50);
    chk("t2_err_range", 64'(bus.status[28]), 64'd1);
    chk("t2_cnt", 64'(bus.status[15:0]), 64'd2);
    issue(2'd0, 1'b1, 7, 0, 'h55);
    push_wr(~exp_bank, 7, 1, 'h55);
    chk("t2_clr", 64'(bus.status[28]), 64'd0);
    wait_idle("t2b", 20);

    // clear whole inactive bank; go toggle mid-stream must not disturb it
    base = we_cnt;
    issue(2'd3, 1'b0, 77, 5, 'hFFFF);
    push_wr(~exp_bank, 0, 1 << AW, 0);
    n = 0;
    while ((we_cnt - base) < 500 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t3_reach500", 64'(n < 1000), 64'd1);
    toggle_go();
    chk("t3_overrun", 64'(bus.status[27]), 64'd1);
    chk("t3_busy", 64'(bus.status[31]), 64'd1);
    wait_idle("t3", 1200);
    chk("t3_strobes", 64'(we_cnt - base), 64'd1024);
    chk("t3_cnt", 64'(bus.status[15:0]), 64'd4);

    // commit: sync on capture edge ignored, swap on the next one
    bus.frame_sync = 1'b1;
    issue(2'd2, 1'b0, 0, 0, 0);
    bus.frame_sync = 1'b0;
    chk("t4_pend0", 64'(bus.status[30]), 64'd1);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk("t4_pend", 64'(bus.status[30]), 64'd1);
      chk("t4_bank_hold", 64'(bus.coef_bank), 64'd0);
    end
    bus.frame_sync = 1'b1;
    @(posedge clk); #1;
    bus.frame_sync = 1'b0;
    exp_bank = 1'b1;
    chk("t4_pend_clr", 64'(bus.status[30]), 64'd0);
    chk("t4_bank", 64'(bus.coef_bank), 64'(exp_bank));
    chk("t4_stat_bank", 64'(bus.status[29]), 64'(exp_bank));
    chk("t4_busy", 64'(bus.status[31]), 64'd0);
    issue(2'd0, 1'b0, 3, 0, 'h0BAD);
    push_wr(~exp_bank, 3, 1, 'h0BAD);
    wait_idle("t4", 20);

    // reset in the middle of a fill
    base = we_cnt;
    issue(2'd1, 1'b0, 0, 99, 'hA5A5);
    push_wr(~exp_bank, 0, 100, 'hA5A5);
    n = 0;
    while ((we_cnt - base) < 40 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reach40", 64'(n < 200), 64'd1);
    do_reset();
    chk("t5_we", 64'(bus.coef_we), 64'd0);
    chk("t5_status", 64'(bus.status), 64'd0);
    chk("t5_bank", 64'(bus.coef_bank), 64'd0);
    rst = 1'b0;
    issue(2'd0, 1'b0, 9, 0, 'h77);
    push_wr(~exp_bank, 9, 1, 'h77);
    chk("t5_accept", 64'(bus.status[31]), 64'd1);
    wait_idle("t5", 20);
    chk("t5_cnt", 64'(bus.status[15:0]), 64'd1);

    // back-to-back go toggles: second one is an overrun
    do_reset();
    rst = 1'b0;
    issue(2'd0, 1'b0, 2, 0, 'h11);
    push_wr(~exp_bank, 2, 1, 'h11);
    toggle_go();
    chk("t6_overrun", 64'(bus.status[27]), 64'd1);
    chk("t6_busy", 64'(bus.status[31]), 64'd1);
    chk("t6_cnt", 64'(bus.status[15:0]), 64'd1);
    wait_idle("t6", 20);
    chk("t6_cnt_end", 64'(bus.status[15:0]), 64'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
